// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and FSM encoding for the shared LFSR controller.
package lfsr_pkg;
  localparam int LFSR_W = 32;
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    OFFER   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, search starts just after last_grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int LW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant
);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  logic [N_REQ-1:0] w_bit;
  // Walk from lowest to highest priority so the nearest set request wins.
  always_comb begin
    grant = '0;
    w_bit = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_bit = ONE << ((int'(last_grant) + i) % N_REQ);
      grant = |(req & w_bit) ? w_bit : grant;
    end
  end
endmodule

// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: round-robin sharing of one 32-bit Fibonacci LFSR,
// STEPS shifts per delivered word, with deferred run-time reseeding.
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int                N_REQ = 4,
  parameter int                STEPS = 4,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic              seed_pending,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [N_REQ-1:0]  rsp_valid,
  output logic [LFSR_W-1:0] rsp_data,
  output logic [N_REQ-1:0]  gnt,
  output logic              busy,
  output logic [15:0]       words_served
);
  localparam int LW = $clog2(N_REQ);

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr, r_seed_val, r_data;
  logic              r_seed_pend;
  logic [7:0]        r_step;
  logic [LW-1:0]     r_last, r_gidx, w_arb_idx;
  logic [N_REQ-1:0]  r_gnt, r_valid, w_arb;
  logic [15:0]       r_served;
  logic [LFSR_W-1:0] w_next;
  logic              w_held, w_hs;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .last_grant(r_last),
    .grant     (w_arb)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < N_REQ; i++) w_arb_idx = w_arb[i] ? LW'(i) : w_arb_idx;
  end

  assign w_next = {r_lfsr[LFSR_W-2:0], r_lfsr[TAP_A] ^ r_lfsr[TAP_B] ^ r_lfsr[TAP_C] ^ r_lfsr[TAP_D]};
  assign w_held = |(req & r_gnt);
  assign w_hs   = |(rsp_ready & r_valid);

  // An accepted word beats a same-cycle withdrawal: the consumer already took it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED;
      r_seed_val  <= '0;
      r_seed_pend <= 1'b0;
      r_step      <= '0;
      r_last      <= LW'(N_REQ - 1);
      r_gidx      <= '0;
      r_gnt       <= '0;
      r_valid     <= '0;
      r_data      <= '0;
      r_served    <= '0;
    end else begin
      if (seed_load) begin
        r_seed_val  <= (seed_value == '0) ? SEED : seed_value;
        r_seed_pend <= 1'b1;
      end else if (r_state == IDLE && r_seed_pend) begin
        r_seed_pend <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (r_seed_pend) begin
            r_lfsr <= r_seed_val;
          end else if (|req) begin
            r_gnt   <= w_arb;
            r_gidx  <= w_arb_idx;
            r_step  <= 8'(STEPS - 1);
            r_state <= ADVANCE;
          end
        end
        ADVANCE: begin
          r_lfsr <= w_next;
          if (!w_held) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= r_gidx;
          end else if (r_step == 8'd0) begin
            r_state <= OFFER;
            r_valid <= r_gnt;
            r_data  <= w_next;
          end else begin
            r_step <= r_step - 8'd1;
          end
        end
        OFFER: begin
          if (w_hs || !w_held) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_valid  <= '0;
            r_last   <= r_gidx;
            r_served <= w_hs ? r_served + 16'd1 : r_served;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign seed_pending = r_seed_pend;
  assign rsp_valid    = r_valid;
  assign rsp_data     = r_data;
  assign gnt          = r_gnt;
  assign busy         = r_state != IDLE;
  assign words_served = r_served;
endmodule
